// File: rtl/gray_serial_decoder.sv
// gray_serial_decoder: bit-serial Gray-to-binary receiver.
// Takes one Gray bit per cycle (MSB first) on a valid/ready port, converts
// it to binary on the fly and presents the assembled W-bit word on a
// valid/ready output port.
//
// Optional feature macro: GRAY_PARITY_EN
//   When defined, each word is followed by an even-parity bit covering the
//   W Gray bits; m_err reports a mismatch alongside m_valid.
//
// state | meaning
// IDLE  | waiting for a bit flagged s_first; other bits are dropped
// SHIFT | collecting the remaining data bits of the current word
// PAR   | expecting the trailing parity bit (GRAY_PARITY_EN only)
// HOLD  | word presented on m_data, waiting for m_ready
module gray_serial_decoder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_bit,
    input  logic         s_first,
    output logic         m_valid,
    input  logic         m_ready,
`ifdef GRAY_PARITY_EN
    output logic         m_err,
`endif
    output logic [W-1:0] m_data
);

    localparam int CW = $clog2(W + 1);

`ifdef GRAY_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        PAR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          r_q, r_d;
    logic [W-2:0]  shreg_q, shreg_d;
    logic [W-1:0]  m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          s_ready_q, s_ready_d;
`ifdef GRAY_PARITY_EN
    logic          par_q, par_d;
    logic          m_err_q, m_err_d;
`endif

    logic accept;
    logic b_next;
    logic last_data;

    assign accept    = s_valid && s_ready_q;
    // The MSB of a word passes straight through; later bits fold in the
    // previously produced binary bit.
    assign b_next    = (state_q == IDLE || s_first) ? s_bit : (r_q ^ s_bit);
    assign last_data = (cnt_q == CW'(W - 1));

    // Next-state and datapath update for one accepted bit or output handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        shreg_d   = shreg_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        s_ready_d = s_ready_q;
`ifdef GRAY_PARITY_EN
        par_d     = par_q;
        m_err_d   = m_err_q;
`endif
        case (state_q)
            IDLE, SHIFT
`ifdef GRAY_PARITY_EN
            , PAR
`endif
            : begin
                if (accept && s_first) begin
                    // New MSB: also abandons any partial word in progress.
                    state_d    = SHIFT;
                    cnt_d      = CW'(1);
                    r_d        = b_next;
                    shreg_d    = '0;
                    shreg_d[0] = b_next;
`ifdef GRAY_PARITY_EN
                    par_d      = s_bit;
`endif
                end else if (accept && state_q == SHIFT) begin
                    cnt_d = cnt_q + CW'(1);
                    r_d   = b_next;
`ifdef GRAY_PARITY_EN
                    par_d = par_q ^ s_bit;
`endif
                    if (last_data) begin
`ifdef GRAY_PARITY_EN
                        // Word bits complete; r keeps the LSB until parity arrives.
                        state_d   = PAR;
`else
                        state_d   = HOLD;
                        m_valid_d = 1'b1;
                        s_ready_d = 1'b0;
                        m_data_d  = {shreg_q, b_next};
`endif
                    end else begin
                        shreg_d    = shreg_q << 1;
                        shreg_d[0] = b_next;
                    end
                end
`ifdef GRAY_PARITY_EN
                else if (accept && state_q == PAR) begin
                    state_d   = HOLD;
                    m_valid_d = 1'b1;
                    s_ready_d = 1'b0;
                    m_data_d  = {shreg_q, r_q};
                    m_err_d   = par_q ^ s_bit;
                end
`endif
            end
            HOLD: begin
                if (m_ready) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
`ifdef GRAY_PARITY_EN
                    m_err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                m_valid_d = 1'b0;
                s_ready_d = 1'b1;
            end
        endcase
    end

    // Control FSM and datapath registers with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r_q       <= 1'b0;
            shreg_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
`ifdef GRAY_PARITY_EN
            par_q     <= 1'b0;
            m_err_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            shreg_q   <= shreg_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
`ifdef GRAY_PARITY_EN
            par_q     <= par_d;
            m_err_q   <= m_err_d;
`endif
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
`ifdef GRAY_PARITY_EN
    assign m_err   = m_err_q;
`endif

endmodule

// File: tb/tb_gray_serial_decoder.sv
// Testbench for gray_serial_decoder with W=4.
module tb_gray_serial_decoder;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic         s_bit;
    logic         s_first;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
`ifdef GRAY_PARITY_EN
    logic         m_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    gray_serial_decoder #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_bit   (s_bit),
        .s_first (s_first),
        .m_valid (m_valid),
        .m_ready (m_ready),
`ifdef GRAY_PARITY_EN
        .m_err   (m_err),
`endif
        .m_data  (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray to binary as a prefix XOR of all right shifts.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int k = 0; k < W; k++) b = b ^ (g >> k);
        return b;
    endfunction

    // Drive one bit after an optional idle gap; returns #1 after the accepting edge.
    task automatic send_bit(input logic b, input logic first, input int gap);
        int n;
        repeat (gap) begin
            s_valid = 1'b0;
            s_bit   = 1'($urandom);
            s_first = 1'($urandom);
            @(posedge clk); #1;
        end
        n = 0;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_bit_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        end
        s_valid = 1'b1;
        s_bit   = b;
        s_first = first;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    // Full word MSB first with s_first on the MSB, plus parity bit when enabled.
    task automatic send_word(input logic [W-1:0] g, input logic p, input int maxgap);
        for (int i = W - 1; i >= 0; i--)
            send_bit(g[i], (i == W - 1), $urandom_range(0, maxgap));
`ifdef GRAY_PARITY_EN
        send_bit(p, 1'b0, $urandom_range(0, maxgap));
`else
        if (p === 1'bx) $display("note: parity argument unused");
`endif
    endtask

    task automatic test_reset();
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
        n_cmp++;
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
        n_cmp++;
        if (m_data !== '0) begin n_err++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        n_cmp++;
`ifdef GRAY_PARITY_EN
        if (m_err !== 1'b0) begin n_err++; $display("FAIL reset_m_err: got %0b want 0", m_err); end
        n_cmp++;
`endif
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        send_word(4'b0110, 1'b0, 0);
        if (m_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b want 1", m_valid); end
        n_cmp++;
        if (m_data !== 4'b0100) begin n_err++; $display("FAIL basic_data: got %b want 0100", m_data); end
        n_cmp++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL basic_hold_ready: got %0b want 0", s_ready); end
        n_cmp++;
        @(posedge clk); #1;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse: m_valid got %0b want 0", m_valid); end
        n_cmp++;
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready: got %0b want 1", s_ready); end
        n_cmp++;
        if (m_data !== 4'b0100) begin n_err++; $display("FAIL basic_data_kept: got %b want 0100", m_data); end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        send_word(4'b1000, 1'b0, 0);
        if (m_data !== 4'b1111 || m_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_first: got data=%b valid=%0b want 1111/1", m_data, m_valid);
        end
        n_cmp++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL b2b_first_ready: got %0b want 0", s_ready); end
        n_cmp++;
        send_word(4'b0000, 1'b0, 0);
        if (m_data !== 4'b0000 || m_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_second: got data=%b valid=%0b want 0000/1", m_data, m_valid);
        end
        n_cmp++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_ready: got %0b want 0", s_ready); end
        n_cmp++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        send_word(4'b0011, 1'b0, 0);
        for (int c = 0; c < 5; c++) begin
            if (m_valid !== 1'b1 || m_data !== 4'b0010 || s_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: got valid=%0b data=%b ready=%0b want 1/0010/0",
                         c, m_valid, m_data, s_ready);
            end
            n_cmp++;
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release: got valid=%0b ready=%0b want 0/1", m_valid, s_ready);
        end
        n_cmp++;
    endtask

    task automatic test_resync();
        logic [W-1:0] g;
        m_ready = 1'b1;
        // Stray bits in IDLE must be dropped.
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 0);
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++; $display("FAIL idle_discard: got valid=%0b ready=%0b want 0/1", m_valid, s_ready);
        end
        n_cmp++;
        // Two bits of an abandoned word, then a full new word.
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        g = 4'b0101;
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(g[i], (i == W - 1), 0);
            if (i != 0) begin
                if (m_valid !== 1'b0) begin
                    n_err++; $display("FAIL resync_early_valid bit%0d: got %0b want 0", i, m_valid);
                end
                n_cmp++;
            end
        end
`ifdef GRAY_PARITY_EN
        send_bit(1'b0, 1'b0, 0);
`endif
        if (m_valid !== 1'b1 || m_data !== 4'b0110) begin
            n_err++; $display("FAIL resync_word: got valid=%0b data=%b want 1/0110", m_valid, m_data);
        end
        n_cmp++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got valid=%0b ready=%0b data=%b want 0/1/0000", m_valid, s_ready, m_data);
        end
        n_cmp++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(4'b1100, 1'b0, 0);
        if (m_valid !== 1'b1 || m_data !== 4'b1000) begin
            n_err++; $display("FAIL reset_mid_next: got valid=%0b data=%b want 1/1000", m_valid, m_data);
        end
        n_cmp++;
        @(posedge clk); #1;
    endtask

`ifdef GRAY_PARITY_EN
    task automatic test_parity();
        m_ready = 1'b0;
        send_word(4'b0110, 1'b0, 0);
        if (m_valid !== 1'b1 || m_err !== 1'b0 || m_data !== 4'b0100) begin
            n_err++; $display("FAIL parity_ok: got valid=%0b err=%0b data=%b want 1/0/0100", m_valid, m_err, m_data);
        end
        n_cmp++;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        send_word(4'b0110, 1'b1, 0);
        if (m_valid !== 1'b1 || m_err !== 1'b1 || m_data !== 4'b0100) begin
            n_err++; $display("FAIL parity_bad: got valid=%0b err=%0b data=%b want 1/1/0100", m_valid, m_err, m_data);
        end
        n_cmp++;
        m_ready = 1'b1;
        @(posedge clk); #1;
        if (m_err !== 1'b0 || m_valid !== 1'b0) begin
            n_err++; $display("FAIL parity_clear: got err=%0b valid=%0b want 0/0", m_err, m_valid);
        end
        n_cmp++;
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] g;
        logic [W-1:0] exp_b;
        logic         p;
        int           bp;
        for (int w = 0; w < 40; w++) begin
            g     = W'($urandom);
            p     = 1'($urandom);
            exp_b = gray2bin(g);
            bp    = $urandom_range(0, 3);
            m_ready = 1'b0;
            send_word(g, p, 2);
            for (int c = 0; c <= bp; c++) begin
                if (m_valid !== 1'b1 || m_data !== exp_b || s_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_word%0d cyc%0d g=%b: got valid=%0b data=%b ready=%0b want 1/%b/0",
                             w, c, g, m_valid, m_data, s_ready, exp_b);
                end
                n_cmp++;
`ifdef GRAY_PARITY_EN
                if (m_err !== ((^g) ^ p)) begin
                    n_err++; $display("FAIL rand_err%0d g=%b p=%0b: got %0b want %0b", w, g, p, m_err, (^g) ^ p);
                end
                n_cmp++;
`endif
                if (c < bp) begin
                    @(posedge clk); #1;
                end
            end
            m_ready = 1'b1;
            @(posedge clk); #1;
            if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
                n_err++; $display("FAIL rand_take%0d: got valid=%0b ready=%0b want 0/1", w, m_valid, s_ready);
            end
            n_cmp++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_bit   = 1'b0;
        s_first = 1'b0;
        m_ready = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_reset_mid();
`ifdef GRAY_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
